// File: rtl/wb_regfile_pkg.sv
// Shared write-back encodings and types for the register file, decode/control and MEM/WB stage.
package wb_regfile_pkg;

  localparam logic [1:0] MTR_ALU = 2'b00;
  localparam logic [1:0] MTR_MEM = 2'b01;
  localparam logic [1:0] MTR_PC4 = 2'b10;
  localparam logic [1:0] MTR_RSV = 2'b11;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef logic [31:0] word_t;

endpackage

// File: rtl/wb_regfile_select.sv
// Write-back source mux: picks the value retired into the register file.
module wb_select
  import wb_regfile_pkg::*;
(
  input  logic [1:0]  MemtoReg,
  input  logic [31:0] ALU_out,
  input  logic [31:0] Read_data,
  input  logic [31:0] PC_plus_4,
  output logic [31:0] Write_data
);

  // The reserved encoding yields zero so a suppressed write never forwards junk.
  always_comb begin
    Write_data = '0;
    case (MemtoReg)
      MTR_ALU: Write_data = ALU_out;
      MTR_MEM: Write_data = Read_data;
      MTR_PC4: Write_data = PC_plus_4;
      default: Write_data = '0;
    endcase
  end

endmodule

// File: rtl/wb_regfile.sv
// 31 x 32-bit register file with a qualified write-back port and two combinational read ports.
module wb_regfile
  import wb_regfile_pkg::*;
#(
  parameter int BYPASS = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] PC_plus_4,
  input  logic [31:0] ALU_out,
  input  logic [31:0] Read_data,
  input  logic        RegWrite,
  input  logic [1:0]  MemtoReg,
  input  logic [4:0]  Write_register,
  input  logic [4:0]  Read_register1,
  input  logic [4:0]  Read_register2,
  output logic [31:0] Read_data1,
  output logic [31:0] Read_data2,
  output logic [31:0] Write_data,
  output logic        Write_en
);

  word_t regs [1:31];

  wb_select u_select (
    .MemtoReg   (MemtoReg),
    .ALU_out    (ALU_out),
    .Read_data  (Read_data),
    .PC_plus_4  (PC_plus_4),
    .Write_data (Write_data)
  );

  // Qualification also folds in reset, so nothing downstream sees a strobe while in reset.
  assign Write_en = reset & RegWrite & (Write_register != REG_ZERO) & (MemtoReg != MTR_RSV);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 1; i < 32; i++) begin
        regs[i] <= '0;
      end
    end else if (Write_en) begin
      regs[Write_register] <= Write_data;
    end
  end

  // Index 0 has no storage; Write_en already excludes it, so bypass can never hit it.
  always_comb begin
    Read_data1 = '0;
    if (reset && (Read_register1 != REG_ZERO)) begin
      if ((BYPASS != 0) && Write_en && (Read_register1 == Write_register))
        Read_data1 = Write_data;
      else
        Read_data1 = regs[Read_register1];
    end
  end

  always_comb begin
    Read_data2 = '0;
    if (reset && (Read_register2 != REG_ZERO)) begin
      if ((BYPASS != 0) && Write_en && (Read_register2 == Write_register))
        Read_data2 = Write_data;
      else
        Read_data2 = regs[Read_register2];
    end
  end

endmodule

// File: tb/tb_wb_regfile.sv
// Bench for wb_regfile: one bypassing and one non-bypassing instance driven in lockstep against an array model.
module tb_wb_regfile;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] PC_plus_4, ALU_out, Read_data;
  logic        RegWrite;
  logic [1:0]  MemtoReg;
  logic [4:0]  Write_register, Read_register1, Read_register2;

  logic [31:0] rd1_b1, rd2_b1, wd_b1;
  logic        we_b1;
  logic [31:0] rd1_b0, rd2_b0, wd_b0;
  logic        we_b0;

  int total = 0;
  int bad = 0;

  logic [31:0] model [32];

  always #5 clk = ~clk;

  wb_regfile #(.BYPASS(1)) dut_b1 (
    .clk(clk), .reset(reset), .PC_plus_4(PC_plus_4), .ALU_out(ALU_out),
    .Read_data(Read_data), .RegWrite(RegWrite), .MemtoReg(MemtoReg),
    .Write_register(Write_register), .Read_register1(Read_register1),
    .Read_register2(Read_register2), .Read_data1(rd1_b1), .Read_data2(rd2_b1),
    .Write_data(wd_b1), .Write_en(we_b1)
  );

  wb_regfile #(.BYPASS(0)) dut_b0 (
    .clk(clk), .reset(reset), .PC_plus_4(PC_plus_4), .ALU_out(ALU_out),
    .Read_data(Read_data), .RegWrite(RegWrite), .MemtoReg(MemtoReg),
    .Write_register(Write_register), .Read_register1(Read_register1),
    .Read_register2(Read_register2), .Read_data1(rd1_b0), .Read_data2(rd2_b0),
    .Write_data(wd_b0), .Write_en(we_b0)
  );

  function automatic logic [31:0] exp_wd();
    case (MemtoReg)
      2'b00:   return ALU_out;
      2'b01:   return Read_data;
      2'b10:   return PC_plus_4;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic exp_we();
    return (reset === 1'b1) && (RegWrite === 1'b1) && (Write_register !== 5'd0) &&
           (MemtoReg !== 2'b11);
  endfunction

  function automatic logic [31:0] exp_read(input logic [4:0] idx, input bit bypass);
    if (reset !== 1'b1 || idx == 5'd0) return 32'h0;
    if (bypass && exp_we() && idx == Write_register) return exp_wd();
    return model[idx];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic checkOutput(input string tag, input bit check_wd);
    if (check_wd) begin
      chk({tag, ".wd_b1"}, wd_b1, exp_wd());
      chk({tag, ".wd_b0"}, wd_b0, exp_wd());
    end
    chk({tag, ".we_b1"}, {31'h0, we_b1}, {31'h0, exp_we()});
    chk({tag, ".we_b0"}, {31'h0, we_b0}, {31'h0, exp_we()});
    chk({tag, ".rd1_b1"}, rd1_b1, exp_read(Read_register1, 1'b1));
    chk({tag, ".rd2_b1"}, rd2_b1, exp_read(Read_register2, 1'b1));
    chk({tag, ".rd1_b0"}, rd1_b0, exp_read(Read_register1, 1'b0));
    chk({tag, ".rd2_b0"}, rd2_b0, exp_read(Read_register2, 1'b0));
  endtask

  task automatic applyStimulus(input string tag, input logic rw, input logic [1:0] mtr,
                               input logic [4:0] wr, input logic [31:0] alu,
                               input logic [31:0] mem, input logic [31:0] pc4,
                               input logic [4:0] r1, input logic [4:0] r2);
    logic        we_now;
    logic [31:0] wd_now;
    RegWrite = rw; MemtoReg = mtr; Write_register = wr;
    ALU_out = alu; Read_data = mem; PC_plus_4 = pc4;
    Read_register1 = r1; Read_register2 = r2;
    #1;
    checkOutput(tag, 1'b1);
    we_now = exp_we();
    wd_now = exp_wd();
    @(posedge clk);
    if (we_now) model[Write_register] = wd_now;
    #1;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
    reset = 1'b0;
    RegWrite = 1'b0; MemtoReg = 2'b00; Write_register = 5'd7;
    ALU_out = 32'h1111_2222; Read_data = 32'h3333_4444; PC_plus_4 = 32'h5555_6666;
    Read_register1 = 5'd7; Read_register2 = 5'd0;
    #12;
    RegWrite = 1'b1;
    #1;
    checkOutput("in_reset", 1'b1);

    @(negedge clk);
    reset = 1'b1;
    RegWrite = 1'b0;
    for (int i = 0; i < 32; i++) begin
      Read_register1 = 5'(i);
      Read_register2 = 5'(31 - i);
      #1;
      chk("post_reset.rd1", rd1_b1, 32'h0);
      chk("post_reset.rd2", rd2_b0, 32'h0);
    end
    @(posedge clk);
    #1;

    applyStimulus("alu_w8",  1, 2'b00, 5'd8,  32'h1234_5678, 32'h0, 32'h0, 5'd8, 5'd0);
    applyStimulus("mem_w9",  1, 2'b01, 5'd9,  32'h0, 32'hDEAD_BEEF, 32'h0, 5'd8, 5'd9);
    applyStimulus("rd_8_9",  0, 2'b00, 5'd0,  32'h0, 32'h0, 32'h0, 5'd8, 5'd9);
    chk("reg8_const", rd1_b0, 32'h1234_5678);
    chk("reg9_const", rd2_b0, 32'hDEAD_BEEF);
    applyStimulus("pc4_w31", 1, 2'b10, 5'd31, 32'h0, 32'h0, 32'h0040_0010, 5'd31, 5'd0);
    applyStimulus("pc4_w0",  1, 2'b10, 5'd0,  32'h0, 32'h0, 32'h0040_0010, 5'd31, 5'd0);
    chk("reg31_const", rd1_b0, 32'h0040_0010);

    applyStimulus("w5_old",  1, 2'b00, 5'd5, 32'h0000_1111, 32'h0, 32'h0, 5'd0, 5'd0);
    RegWrite = 1'b1; MemtoReg = 2'b00; Write_register = 5'd5; ALU_out = 32'hCAFE_0001;
    Read_register1 = 5'd5; Read_register2 = 5'd5;
    #1;
    chk("byp1.rd1", rd1_b1, 32'hCAFE_0001);
    chk("byp1.rd2", rd2_b1, 32'hCAFE_0001);
    chk("byp0.rd1", rd1_b0, 32'h0000_1111);
    chk("byp0.rd2", rd2_b0, 32'h0000_1111);
    @(posedge clk);
    model[5] = 32'hCAFE_0001;
    #1;
    RegWrite = 1'b0;
    #1;
    chk("byp0_next.rd1", rd1_b0, 32'hCAFE_0001);
    chk("byp0_next.rd2", rd2_b0, 32'hCAFE_0001);

    applyStimulus("w4",      1, 2'b00, 5'd4, 32'h0404_0404, 32'h0, 32'h0, 5'd0, 5'd0);
    RegWrite = 1'b1; MemtoReg = 2'b11; Write_register = 5'd4; Read_register1 = 5'd4;
    #1;
    chk("rsv.we", {31'h0, we_b1}, 32'h0);
    chk("rsv.wd", wd_b1, 32'h0);
    @(posedge clk);
    #1;
    RegWrite = 1'b0;
    #1;
    chk("rsv.reg4", rd1_b1, 32'h0404_0404);

    RegWrite = 1'b0; MemtoReg = 2'bxx; Write_register = 5'bxxxxx;
    Read_register1 = 5'd4; Read_register2 = 5'd5;
    #1;
    checkOutput("x_ctrl", 1'b0);
    @(posedge clk);
    #1;
    checkOutput("x_ctrl_after", 1'b0);

    applyStimulus("w3",      1, 2'b00, 5'd3, 32'hAAAA_AAAA, 32'h0, 32'h0, 5'd3, 5'd0);
    RegWrite = 1'b1; MemtoReg = 2'b00; Write_register = 5'd3; ALU_out = 32'h5555_5555;
    Read_register1 = 5'd3; Read_register2 = 5'd3;
    #1;
    reset = 1'b0;
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
    #1;
    chk("rst_mid.rd1", rd1_b1, 32'h0);
    chk("rst_mid.we", {31'h0, we_b1}, 32'h0);
    chk("rst_mid.wd", wd_b1, 32'h5555_5555);
    @(posedge clk);
    #2;
    reset = 1'b1;
    RegWrite = 1'b0;
    #1;
    chk("rst_rel.rd1_b1", rd1_b1, 32'h0);
    chk("rst_rel.rd2_b0", rd2_b0, 32'h0);
    @(posedge clk);
    #1;
    applyStimulus("first_w", 1, 2'b01, 5'd3, 32'h0, 32'h0BAD_F00D, 32'h0, 5'd0, 5'd0);
    applyStimulus("first_r", 0, 2'b00, 5'd0, 32'h0, 32'h0, 32'h0, 5'd3, 5'd3);

    for (int n = 0; n < 300; n++) begin
      logic [4:0] wr, r1, r2;
      wr = 5'($urandom_range(0, 31));
      r1 = ($urandom_range(0, 3) == 0) ? wr : 5'($urandom_range(0, 31));
      r2 = ($urandom_range(0, 3) == 0) ? wr : 5'($urandom_range(0, 31));
      applyStimulus("rand", 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), wr,
                    $urandom, $urandom, $urandom, r1, r2);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wb_regfile.md
WB_REGFILE -- requirements
Module: wb_regfile

Interface
REQ-001 Parameter BYPASS, default 1, meaning: 1 = same-cycle write-to-read bypass enabled; 0 = reads return stored contents only.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset; one clock only in this block.
REQ-004 PC_plus_4  input  32  write-back return address, from MEM/WB register.
REQ-005 ALU_out  input  32  ALU result, from MEM/WB register.
REQ-006 Read_data  input  32  data-memory load result, from MEM/WB register.
REQ-007 RegWrite  input  1  write enable for the write-back port.
REQ-008 MemtoReg  input  2  source select: 00 ALU_out, 01 Read_data, 10 PC_plus_4, 11 reserved.
REQ-009 Write_register  input  5  destination register index.
REQ-010 Read_register1  input  5  read port 1 index (ID stage).
REQ-011 Read_register2  input  5  read port 2 index (ID stage).
REQ-012 Read_data1  output  32  read port 1 data, combinational.
REQ-013 Read_data2  output  32  read port 2 data, combinational.
REQ-014 Write_data  output  32  selected write-back value, combinational; feeds EX forwarding.
REQ-015 Write_en  output  1  qualified write strobe actually applied this cycle.

Function
REQ-016 Storage: 31 x 32-bit registers, indices 1..31; index 0 has no storage and always reads 32'h0.
REQ-017 Write_data = ALU_out / Read_data / PC_plus_4 for MemtoReg 00 / 01 / 10; 32'h0 for 11.
REQ-018 Write_en = RegWrite AND (Write_register != 0) AND (MemtoReg != 11).
REQ-019 On rising clk with Write_en=1, register[Write_register] <= Write_data; zero write latency beyond that edge, no other register changes.
REQ-020 Write_register=0 with RegWrite=1: no state change, no error; reads of 0 stay 32'h0.
REQ-021 MemtoReg=11 with RegWrite=1: write suppressed, Write_en=0.
REQ-022 Reads: Read_dataN = register[Read_registerN], purely combinational, both ports independent, same index on both ports permitted.
REQ-023 BYPASS=1: if Write_en=1 and Read_registerN == Write_register, Read_dataN = Write_data in the same cycle (write-then-read semantics).
REQ-024 BYPASS=0: same-index read returns the pre-edge stored value; updated value visible the cycle after the edge.
REQ-025 Bypass never applies to index 0 (follows from REQ-018).
REQ-026 X/undefined on MemtoReg or Write_register while RegWrite=0 has no effect on state.

Reset
REQ-027 reset low asynchronously clears registers 1..31 to 32'h0, independent of clk.
REQ-028 While reset low: no writes occur, Write_en forced 0, Read_data1/2 = 32'h0.
REQ-029 Write_data stays combinational during reset (follows MemtoReg select).
REQ-030 Reset asserted mid-write (same cycle as a qualifying edge): reset wins, register stays 32'h0.
REQ-031 First write accepted on the first rising clk after reset deasserts.

Structure
REQ-032 Shared package holds MemtoReg encodings (MTR_ALU=2'b00, MTR_MEM=2'b01, MTR_PC4=2'b10) and REG_ZERO=5'd0, shared with decode/control and the MEM/WB stage.
REQ-033 One sub-module, wb_select: combinational MemtoReg mux producing Write_data; storage, qualification and read/bypass logic remain in wb_regfile.

Verification
REQ-034 Reset low, then high; read all 32 indices on both ports -> every read = 32'h0.
REQ-035 RegWrite=1, MemtoReg=00, ALU_out=32'h1234_5678, Write_register=8; next cycle read 8 -> 32'h1234_5678; MemtoReg=01, Read_data=32'hDEAD_BEEF, Write_register=9 -> reg9=32'hDEAD_BEEF.
REQ-036 MemtoReg=10, PC_plus_4=32'h0040_0010, Write_register=31 -> reg31=32'h0040_0010; same stimulus with Write_register=0 -> Write_en=0, read 0 = 32'h0.
REQ-037 BYPASS=1: write 32'hCAFE_0001 to reg5 while Read_register1=Read_register2=5 -> both ports show 32'hCAFE_0001 in the write cycle; BYPASS=0 -> old value that cycle, new value next cycle.
REQ-038 reg3=32'hAAAA_AAAA; assert reset between edges with RegWrite=1, Write_register=3, ALU_out=32'h5555_5555 -> reg3 reads 32'h0 immediately and after release.
REQ-039 MemtoReg=11, RegWrite=1, Write_register=4 -> Write_en=0, Write_data=32'h0, reg4 unchanged.
